// File: rtl/sorter_pkg.sv
// -----------------------------------------------------------------------------
// sorter_pkg
//   Shared definitions for the sorter frame controller:
//     ctrl_state_t    - controller state encoding
//     DEFAULT_TIMEOUT - default watchdog limit for the sort phase, in cycles
//     max_words()     - frame capacity for a given sorter address width
// -----------------------------------------------------------------------------
package sorter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    SORT_WAIT,
    UNLOAD_RD,
    UNLOAD_CAP,
    UNLOAD_OUT
  } ctrl_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  // Number of words the sorter can hold when addressed with awidth bits.
  function automatic int unsigned max_words(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

endpackage : sorter_pkg

// File: rtl/sorter_ctrl.sv
// -----------------------------------------------------------------------------
// sorter_ctrl
//   Frame-level initiator for the sorter block. It takes one frame from a
//   valid/ready input stream, clears the sorter, writes the frame into it,
//   starts the sort, then reads the sorted words back one at a time and
//   presents them on a valid/ready output stream.
//
//   Frames longer than the sorter capacity are truncated: the surplus words
//   are accepted and discarded, and the sticky trunc_o flag is raised. If the
//   sorter does not report completion within TIMEOUT cycles the frame is
//   abandoned, the sorter is cleared, and the sticky timeout_o flag is raised.
//
// Ports
//   clk_i, srst_i        clock; synchronous active-low reset
//   s_data_i/s_valid_i/s_last_i/s_ready_o
//                        input frame stream
//   m_data_o/m_valid_o/m_last_o/m_ready_i
//                        sorted output frame stream
//   srt_wren_o, srt_sort_op_o, srt_output_op_o, srt_clear_op_o,
//   srt_cntr_o, srt_data_o
//                        command/data towards the sorter
//   srt_done_i, srt_data_i
//                        sort completion and read data from the sorter
//   busy_o               a frame is in progress
//   trunc_o              sticky: a frame exceeded the sorter capacity
//   timeout_o            sticky: a sort did not complete in time
// -----------------------------------------------------------------------------
module sorter_ctrl
  import sorter_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              srst_i,

  input  logic [DWIDTH-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,

  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,

  output logic              srt_wren_o,
  output logic              srt_sort_op_o,
  output logic              srt_output_op_o,
  output logic              srt_clear_op_o,
  output logic [AWIDTH-1:0] srt_cntr_o,
  output logic [DWIDTH-1:0] srt_data_o,
  input  logic              srt_done_i,
  input  logic [DWIDTH-1:0] srt_data_i,

  output logic              busy_o,
  output logic              trunc_o,
  output logic              timeout_o
);

  localparam int unsigned MAX_WORDS = max_words(AWIDTH);
  // Wide enough to hold TIMEOUT-1.
  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  localparam logic [AWIDTH:0]  LAST_SLOT = (AWIDTH+1)'(MAX_WORDS - 1);
  localparam logic [WDW-1:0]   WDOG_END  = WDW'(TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;

  // One bit wider than the address so a full frame does not wrap to zero.
  logic [AWIDTH:0]   count_q, count_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [AWIDTH-1:0] cntr_q, cntr_d;
  logic [DWIDTH-1:0] sdata_q, sdata_d;

  // Write strobe for the word accepted in the previous cycle.
  logic              wr_pulse_q, wr_pulse_d;
  // End-of-frame / abort clear strobe, issued in the first IDLE cycle.
  logic              clr_pulse_q, clr_pulse_d;

  logic [DWIDTH-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              trunc_q, trunc_d;
  logic              timeout_q, timeout_d;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    wdog_d      = wdog_q;
    rd_idx_d    = rd_idx_q;
    cntr_d      = cntr_q;
    sdata_d     = sdata_q;
    wr_pulse_d  = 1'b0;
    clr_pulse_d = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    trunc_d     = trunc_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      IDLE: begin
        // The first word stays on the input until LOAD accepts it.
        if (s_valid_i) state_d = CLEAR;
      end

      CLEAR: begin
        count_d = '0;
        state_d = LOAD;
      end

      LOAD: begin
        if (s_valid_i) begin
          sdata_d    = s_data_i;
          wr_pulse_d = 1'b1;
          count_d    = count_q + 1'b1;
          if (s_last_i || (count_q == LAST_SLOT)) begin
            // count_q still holds the pre-increment value: words minus one.
            cntr_d  = count_q[AWIDTH-1:0];
            wdog_d  = '0;
            state_d = SORT_WAIT;
            if (!s_last_i) begin
              trunc_d = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (s_valid_i && s_last_i) begin
          wdog_d  = '0;
          state_d = SORT_WAIT;
        end
      end

      SORT_WAIT: begin
        if (srt_done_i) begin
          rd_idx_d = '0;
          state_d  = UNLOAD_RD;
        end else if (wdog_q == WDOG_END) begin
          timeout_d   = 1'b1;
          clr_pulse_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      UNLOAD_RD: begin
        state_d = UNLOAD_CAP;
      end

      UNLOAD_CAP: begin
        // Read data appears one cycle after the output_op strobe.
        m_data_d  = srt_data_i;
        m_valid_d = 1'b1;
        m_last_d  = (rd_idx_q == cntr_q);
        state_d   = UNLOAD_OUT;
      end

      UNLOAD_OUT: begin
        if (m_ready_i) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            clr_pulse_d = 1'b1;
            state_d     = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = UNLOAD_RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!srst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wdog_q      <= '0;
      rd_idx_q    <= '0;
      cntr_q      <= '0;
      sdata_q     <= '0;
      wr_pulse_q  <= 1'b0;
      clr_pulse_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      trunc_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wdog_q      <= wdog_d;
      rd_idx_q    <= rd_idx_d;
      cntr_q      <= cntr_d;
      sdata_q     <= sdata_d;
      wr_pulse_q  <= wr_pulse_d;
      clr_pulse_q <= clr_pulse_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      trunc_q     <= trunc_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_ready_o       = (state_q == LOAD) || (state_q == DRAIN);

  // The write strobe for the final word lands in the first SORT_WAIT (or
  // DRAIN) cycle, so wren is extended by the pending pulse to keep that
  // strobe a write rather than the start of the sort.
  assign srt_wren_o      = (state_q == LOAD) || wr_pulse_q;
  assign srt_sort_op_o   = wr_pulse_q || (state_q == SORT_WAIT);
  assign srt_output_op_o = (state_q == UNLOAD_RD);
  assign srt_clear_op_o  = (state_q == CLEAR) || clr_pulse_q;
  assign srt_cntr_o      = cntr_q;
  assign srt_data_o      = sdata_q;

  assign m_data_o        = m_data_q;
  assign m_valid_o       = m_valid_q;
  assign m_last_o        = m_last_q;

  assign busy_o          = (state_q != IDLE);
  assign trunc_o         = trunc_q;
  assign timeout_o       = timeout_q;

endmodule : sorter_ctrl

// File: tb/tb_sorter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sorter_ctrl
//   Self-checking bench for sorter_ctrl. A behavioural sorter responder
//   stores written words and returns them in ascending order; expected
//   results come from the frame-level rules (truncate to capacity, sort,
//   last flag on the final word, sticky flags).
// -----------------------------------------------------------------------------
module tb_sorter_ctrl;
  import sorter_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int MAXW = 16;
  localparam int TO   = 1024;

  typedef logic [DW-1:0] wq_t[$];

  typedef struct {
    int            n;
    logic [DW-1:0] w[20];
    int            exp_nout;
    bit            exp_trunc;
  } vec_t;

  logic          clk_i     = 1'b0;
  logic          srst_i    = 1'b0;
  logic [DW-1:0] s_data_i  = '0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i  = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  wire           m_ready_i;
  logic          srt_wren_o, srt_sort_op_o, srt_output_op_o, srt_clear_op_o;
  logic [AW-1:0] srt_cntr_o;
  logic [DW-1:0] srt_data_o;
  logic          srt_done_i = 1'b0;
  logic [DW-1:0] srt_data_i = '0;
  logic          busy_o, trunc_o, timeout_o;

  always #5 clk_i = ~clk_i;

  sorter_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .srt_wren_o(srt_wren_o), .srt_sort_op_o(srt_sort_op_o), .srt_output_op_o(srt_output_op_o),
    .srt_clear_op_o(srt_clear_op_o), .srt_cntr_o(srt_cntr_o), .srt_data_o(srt_data_o),
    .srt_done_i(srt_done_i), .srt_data_i(srt_data_i),
    .busy_o(busy_o), .trunc_o(trunc_o), .timeout_o(timeout_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wq_t sort_words(input wq_t q);
    wq_t r;
    logic [DW-1:0] t;
    r = q;
    for (int i = 1; i < r.size(); i++)
      for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    return r;
  endfunction

  // Output backpressure: random, or forced by the hand-written sequences.
  bit   rdy_rand  = 1'b1;
  logic rdy_val   = 1'b0;
  logic rdy_rnd_q = 1'b0;
  assign m_ready_i = rdy_rand ? rdy_rnd_q : rdy_val;
  always @(negedge clk_i) rdy_rnd_q = ($urandom_range(0, 2) != 0);

  // Behavioural sorter responder.
  bit  done_en  = 1'b1;
  int  done_dly = 3;
  int  sort_cyc = 0;
  int  rptr     = 0;
  wq_t mem;
  wq_t sorted_mem;
  wq_t wr_log;

  always @(negedge clk_i) begin
    if (srt_clear_op_o) begin
      mem.delete();
      srt_done_i = 1'b0;
      sort_cyc   = 0;
      rptr       = 0;
    end else begin
      if (srt_sort_op_o && srt_wren_o) begin
        mem.push_back(srt_data_o);
        wr_log.push_back(srt_data_o);
      end else if (srt_sort_op_o && !srt_done_i) begin
        sort_cyc++;
        if (done_en && sort_cyc >= done_dly) begin
          sorted_mem = sort_words(mem);
          srt_done_i = 1'b1;
        end
      end
      if (srt_output_op_o) begin
        srt_data_i = (rptr < sorted_mem.size()) ? sorted_mem[rptr] : 8'hEE;
        rptr++;
      end
    end
  end

  // Edge monitor: strobe counts and accepted output words.
  int  clr_cnt = 0, sop_cnt = 0, oop_cnt = 0, mval_cnt = 0;
  int  cntr_seen = -1;
  wq_t out_d;
  logic out_l[$];

  always @(posedge clk_i) begin
    if (srt_clear_op_o)  clr_cnt++;
    if (srt_sort_op_o)   sop_cnt++;
    if (srt_output_op_o) begin oop_cnt++; cntr_seen = int'(srt_cntr_o); end
    if (m_valid_o)       mval_cnt++;
    if (m_valid_o && m_ready_i) begin
      out_d.push_back(m_data_o);
      out_l.push_back(m_last_o);
    end
  end

  bit exp_trunc = 1'b0;
  bit exp_tmo   = 1'b0;

  task automatic send_frame(input wq_t words, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < words.size()) begin
      @(negedge clk_i);
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid_i = 1'b0;
        s_data_i  = DW'($urandom);
        s_last_i  = 1'($urandom);
      end else begin
        s_valid_i = 1'b1;
        s_data_i  = words[i];
        s_last_i  = (i == words.size() - 1);
        if (s_ready_o) i++;
      end
      guard++;
      if (guard > 2000) begin
        check("send_bound", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while (busy_o && g < limit) begin @(negedge clk_i); g++; end
    if (busy_o) check("idle_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_mvalid(input int limit);
    int g = 0;
    while (!m_valid_o && g < limit) begin @(negedge clk_i); g++; end
    if (!m_valid_o) check("mvalid_bound", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   32'(s_ready_o),       0);
    check({tag, "_m_data"},    32'(m_data_o),        0);
    check({tag, "_m_valid"},   32'(m_valid_o),       0);
    check({tag, "_m_last"},    32'(m_last_o),        0);
    check({tag, "_wren"},      32'(srt_wren_o),      0);
    check({tag, "_sort_op"},   32'(srt_sort_op_o),   0);
    check({tag, "_output_op"}, 32'(srt_output_op_o), 0);
    check({tag, "_clear_op"},  32'(srt_clear_op_o),  0);
    check({tag, "_cntr"},      32'(srt_cntr_o),      0);
    check({tag, "_srt_data"},  32'(srt_data_o),      0);
    check({tag, "_busy"},      32'(busy_o),          0);
    check({tag, "_trunc"},     32'(trunc_o),         0);
    check({tag, "_timeout"},   32'(timeout_o),       0);
  endtask

  // Full frame through the controller, checked against the frame rules.
  task automatic run_frame(input wq_t words, input bit gaps, input int exp_nl);
    int  nl, wb, ob, cb;
    wq_t loaded, exp_s;
    nl = (words.size() > MAXW) ? MAXW : words.size();
    for (int i = 0; i < nl; i++) loaded.push_back(words[i]);
    exp_s = sort_words(loaded);
    if (words.size() > MAXW) exp_trunc = 1'b1;
    check("frame_nl", 32'(nl), 32'(exp_nl));
    wb = wr_log.size(); ob = out_d.size(); cb = clr_cnt;
    done_dly = $urandom_range(1, 6);
    send_frame(words, gaps);
    wait_idle(3000);
    repeat (2) @(negedge clk_i);
    check("wr_count", 32'(wr_log.size() - wb), 32'(nl));
    for (int i = 0; i < nl && wb + i < wr_log.size(); i++)
      check("wr_data", 32'(wr_log[wb+i]), 32'(loaded[i]));
    check("cntr", 32'(cntr_seen), 32'(nl - 1));
    check("out_count", 32'(out_d.size() - ob), 32'(nl));
    for (int i = 0; i < nl && ob + i < out_d.size(); i++) begin
      check("out_data", 32'(out_d[ob+i]), 32'(exp_s[i]));
      check("out_last", 32'(out_l[ob+i]), 32'(i == nl - 1));
    end
    check("clear_pulses", 32'(clr_cnt - cb), 32'd2);
    check("trunc",   32'(trunc_o),   32'(exp_trunc));
    check("timeout", 32'(timeout_o), 32'(exp_tmo));
    check("idle_mvalid", 32'(m_valid_o), 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL global_bound: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    wq_t  w;
    int   sb, mb, cb, ob, ocb, n;
    logic [DW-1:0] d0;
    logic          l0;

    // Reset state
    srst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    srst_i = 1'b1;
    @(negedge clk_i);
    check("idle_s_ready", 32'(s_ready_o), 0);

    // Directed frame table
    foreach (tbl[k]) for (int j = 0; j < 20; j++) tbl[k].w[j] = DW'($urandom);
    tbl[0].n = 3;  tbl[0].w[0] = 8'h03; tbl[0].w[1] = 8'h01; tbl[0].w[2] = 8'h02;
    tbl[0].exp_nout = 3;  tbl[0].exp_trunc = 1'b0;
    tbl[1].n = 1;  tbl[1].w[0] = 8'h5A;
    tbl[1].exp_nout = 1;  tbl[1].exp_trunc = 1'b0;
    tbl[2].n = 16; tbl[2].exp_nout = 16; tbl[2].exp_trunc = 1'b0;
    tbl[3].n = 20; tbl[3].exp_nout = 16; tbl[3].exp_trunc = 1'b1;

    for (int k = 0; k < 4; k++) begin
      w.delete();
      for (int j = 0; j < tbl[k].n; j++) w.push_back(tbl[k].w[j]);
      run_frame(w, 1'b0, tbl[k].exp_nout);
      check("tbl_trunc", 32'(trunc_o), 32'(tbl[k].exp_trunc));
    end

    // Randomized frames with input gaps and output backpressure
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 22);
      w.delete();
      for (int j = 0; j < n; j++) w.push_back(DW'($urandom));
      run_frame(w, 1'b1, (n > MAXW) ? MAXW : n);
    end

    // Output stall on the second word
    rdy_rand = 1'b0; rdy_val = 1'b0;
    ob = out_d.size();
    w = '{8'hC0, 8'h11, 8'h7E};
    send_frame(w, 1'b0);
    wait_mvalid(200);
    rdy_val = 1'b1;
    @(negedge clk_i);
    rdy_val = 1'b0;
    wait_mvalid(50);
    d0 = m_data_o; l0 = m_last_o; ocb = oop_cnt;
    check("stall_word2", 32'(d0), 32'h7E);
    check("stall_last2", 32'(l0), 32'd0);
    repeat (5) begin
      @(negedge clk_i);
      check("stall_valid", 32'(m_valid_o), 32'd1);
      check("stall_data",  32'(m_data_o),  32'(d0));
      check("stall_last",  32'(m_last_o),  32'(l0));
    end
    check("stall_no_read", 32'(oop_cnt - ocb), 32'd0);
    rdy_val = 1'b1;
    wait_idle(200);
    rdy_val = 1'b0; rdy_rand = 1'b1;
    check("stall_out_count", 32'(out_d.size() - ob), 32'd3);
    if (out_d.size() - ob == 3) begin
      check("stall_out0", 32'(out_d[ob]),   32'h11);
      check("stall_out2", 32'(out_d[ob+2]), 32'hC0);
      check("stall_last_final", 32'(out_l[ob+2]), 32'd1);
    end

    // Sort never completes: watchdog abort
    repeat (2) @(negedge clk_i);
    done_en = 1'b0;
    sb = sop_cnt; mb = mval_cnt; cb = clr_cnt;
    w = '{8'h10, 8'h20};
    send_frame(w, 1'b0);
    wait_idle(TO + 100);
    repeat (2) @(negedge clk_i);
    exp_tmo = 1'b1;
    check("tmo_flag",        32'(timeout_o),      32'd1);
    check("tmo_sort_cycles", 32'(sop_cnt - sb),   32'(1 + TO));
    check("tmo_clears",      32'(clr_cnt - cb),   32'd2);
    check("tmo_no_mvalid",   32'(mval_cnt - mb),  32'd0);
    check("tmo_busy",        32'(busy_o),         32'd0);
    done_en = 1'b1;

    // Reset while holding an output word
    rdy_rand = 1'b0; rdy_val = 1'b0;
    w = '{8'h09, 8'h04, 8'h07, 8'h01};
    send_frame(w, 1'b0);
    wait_mvalid(200);
    srst_i = 1'b0;
    @(negedge clk_i);
    srst_i = 1'b1;
    check_all_zero("rst_unload");
    exp_trunc = 1'b0; exp_tmo = 1'b0;
    cb = clr_cnt; sb = sop_cnt; ocb = oop_cnt;
    repeat (4) @(negedge clk_i);
    check("rst_no_clear",  32'(clr_cnt - cb),  32'd0);
    check("rst_no_sort",   32'(sop_cnt - sb),  32'd0);
    check("rst_no_read",   32'(oop_cnt - ocb), 32'd0);
    rdy_rand = 1'b1;
    w.delete();
    for (int j = 0; j < 6; j++) w.push_back(DW'($urandom));
    run_frame(w, 1'b1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sorter_ctrl
